// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
//   Main control FSM of the multi-cycle CPU. Sequences the shared ALU, PC, IR,
//   register file and unified memory through FETCH / DECODE / EXEC / MEM / WB
//   cycles. It produces the 3-bit ALUOp consumed by ALU_Ctrl and stalls on the
//   memory handshake.
//
//   Memory handshake: mem_read_o / mem_write_o is a request held high for as
//   long as the FSM sits in a memory state. The transfer completes in the cycle
//   where mem_ready_i is high while a request is up. The FSM then leaves the
//   state on the next rising edge. mem_ready_i is ignored whenever no request
//   is raised.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   opcode_i[5:0]       instr[31:26] from the IR, sampled in DECODE
//   mem_ready_i         memory finished the current read/write this cycle
//   pc_write_o          unconditional PC load
//   pc_write_cond_o     conditional PC load (gated by zero ^ branch_ne_o)
//   branch_ne_o         branch sense: 1 = bne
//   pc_source_o[1:0]    00 ALU result, 01 ALUOut, 10 jump target
//   i_or_d_o            memory address select: 0 PC, 1 ALUOut
//   mem_read_o          memory read request
//   mem_write_o         memory write request
//   ir_write_o          IR load
//   reg_write_o         register file write
//   reg_dst_o           0 rt, 1 rd
//   mem_to_reg_o        0 ALUOut, 1 MDR
//   ext_zero_o          zero-extend the immediate
//   alu_src_a_o         0 PC, 1 reg A
//   alu_src_b_o[1:0]    00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
//   alu_op_o[2:0]       ALUOp for ALU_Ctrl
//   instr_done_o        pulse on the last cycle of each instruction
//   illegal_o           pulse in DECODE on an unsupported opcode
//   state_o[3:0]        current state (debug)
//   cycle_cnt_o[31:0]   (MULTI_CYCLE_CTRL_PERF_EN only) non-reset cycle count
//   instr_cnt_o[31:0]   (MULTI_CYCLE_CTRL_PERF_EN only) completed instructions
//
// Optional feature macro: MULTI_CYCLE_CTRL_PERF_EN. It adds the two counters.
// -----------------------------------------------------------------------------
module multi_cycle_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [5:0]  opcode_i,
   input  logic        mem_ready_i,
   output logic        pc_write_o,
   output logic        pc_write_cond_o,
   output logic        branch_ne_o,
   output logic [1:0]  pc_source_o,
   output logic        i_or_d_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic        ir_write_o,
   output logic        reg_write_o,
   output logic        reg_dst_o,
   output logic        mem_to_reg_o,
   output logic        ext_zero_o,
   output logic        alu_src_a_o,
   output logic [1:0]  alu_src_b_o,
   output logic [2:0]  alu_op_o,
   output logic        instr_done_o,
   output logic        illegal_o,
   output logic [3:0]  state_o
`ifdef MULTI_CYCLE_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_cnt_o,
   output logic [31:0] instr_cnt_o
`endif
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC_R   = 4'd7,
      S_WB_R     = 4'd8,
      S_EXEC_I   = 4'd9,
      S_WB_I     = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t     state_q;
   state_t     state_nxt;
   logic [5:0] opcode_q;   // opcode captured in DECODE for the later states

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         opcode_q <= '0;
      end else begin
         state_q <= state_nxt;
         if (state_q == S_DECODE) opcode_q <= opcode_i;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_nxt = S_FETCH;
      case (state_q)
         S_IDLE:     state_nxt = S_FETCH;
         S_FETCH:    state_nxt = mem_ready_i ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode_i)
               OP_RTYPE:                           state_nxt = S_EXEC_R;
               OP_LW, OP_SW:                       state_nxt = S_MEM_ADDR;
               OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI:  state_nxt = S_EXEC_I;
               OP_BEQ, OP_BNE:                     state_nxt = S_BRANCH;
               OP_J:                               state_nxt = S_JUMP;
               default:                            state_nxt = S_FETCH;
            endcase
         end
         S_MEM_ADDR: state_nxt = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   state_nxt = mem_ready_i ? S_MEM_WB : S_MEM_RD;
         S_MEM_WB:   state_nxt = S_FETCH;
         S_MEM_WR:   state_nxt = mem_ready_i ? S_FETCH : S_MEM_WR;
         S_EXEC_R:   state_nxt = S_WB_R;
         S_WB_R:     state_nxt = S_FETCH;
         S_EXEC_I:   state_nxt = S_WB_I;
         S_WB_I:     state_nxt = S_FETCH;
         S_BRANCH:   state_nxt = S_FETCH;
         S_JUMP:     state_nxt = S_FETCH;
         default:    state_nxt = S_FETCH;   // encodings 13-15 recover to FETCH
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      branch_ne_o     = 1'b0;
      pc_source_o     = 2'b00;
      i_or_d_o        = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      reg_write_o     = 1'b0;
      reg_dst_o       = 1'b0;
      mem_to_reg_o    = 1'b0;
      ext_zero_o      = 1'b0;
      alu_src_a_o     = 1'b0;
      alu_src_b_o     = 2'b00;
      alu_op_o        = 3'b000;
      instr_done_o    = 1'b0;
      illegal_o       = 1'b0;
      case (state_q)
         S_FETCH: begin
            // PC+4 is computed while the read is pending. IR and PC load only
            // in the cycle the read completes.
            mem_read_o  = 1'b1;
            alu_src_b_o = 2'b01;
            alu_op_o    = 3'b100;
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
         end
         S_DECODE: begin
            // Branch target PC + (imm<<2) is precomputed into ALUOut.
            alu_src_b_o = 2'b11;
            alu_op_o    = 3'b100;
            case (opcode_i)
               OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI,
               OP_BEQ, OP_BNE, OP_J: illegal_o = 1'b0;
               default:              illegal_o = 1'b1;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            alu_op_o    = 3'b100;
         end
         S_MEM_RD: begin
            mem_read_o = 1'b1;
            i_or_d_o   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 1'b1;
            instr_done_o = 1'b1;
         end
         S_MEM_WR: begin
            mem_write_o  = 1'b1;
            i_or_d_o     = 1'b1;
            instr_done_o = mem_ready_i;
         end
         S_EXEC_R: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = 3'b010;
         end
         S_WB_R: begin
            reg_write_o  = 1'b1;
            reg_dst_o    = 1'b1;
            instr_done_o = 1'b1;
         end
         S_EXEC_I: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            case (opcode_q)
               OP_SLTIU: alu_op_o = 3'b111;
               OP_LUI:   alu_op_o = 3'b101;
               OP_ORI: begin
                  alu_op_o   = 3'b110;
                  ext_zero_o = 1'b1;
               end
               default:  alu_op_o = 3'b100;
            endcase
         end
         S_WB_I: begin
            reg_write_o  = 1'b1;
            instr_done_o = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_o     = 1'b1;
            alu_op_o        = (opcode_q == OP_BNE) ? 3'b001 : 3'b011;
            branch_ne_o     = (opcode_q == OP_BNE);
            pc_write_cond_o = 1'b1;
            pc_source_o     = 2'b01;
            instr_done_o    = 1'b1;
         end
         S_JUMP: begin
            pc_write_o   = 1'b1;
            pc_source_o  = 2'b10;
            instr_done_o = 1'b1;
         end
         default: ;   // IDLE and unused encodings: everything stays 0
      endcase
   end

   assign state_o = state_q;

`ifdef MULTI_CYCLE_CTRL_PERF_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cycle_cnt_o <= '0;
         instr_cnt_o <= '0;
      end else begin
         cycle_cnt_o <= cycle_cnt_o + 32'd1;
         if (instr_done_o) instr_cnt_o <= instr_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//   Self-checking bench for multi_cycle_ctrl. Each instruction is expanded
//   cycle by cycle into an expected control word and a care mask. Both are
//   queued when the cycle's inputs are driven. They are popped and compared
//   against the DUT outputs shortly after the falling edge.
// -----------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

   typedef struct packed {
      logic [3:0] state;
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic [1:0] pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       ext_zero;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       instr_done;
      logic       illegal;
   } ctl_t;

   localparam int W = $bits(ctl_t);

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ------------------------------------------------------------ clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_i       = 1'b1;
   logic [5:0] opcode_i    = '0;
   logic       mem_ready_i = 1'b1;

   logic       pc_write_o, pc_write_cond_o, branch_ne_o, i_or_d_o;
   logic       mem_read_o, mem_write_o, ir_write_o, reg_write_o, reg_dst_o;
   logic       mem_to_reg_o, ext_zero_o, alu_src_a_o, instr_done_o, illegal_o;
   logic [1:0] pc_source_o, alu_src_b_o;
   logic [2:0] alu_op_o;
   logic [3:0] state_o;
`ifdef MULTI_CYCLE_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   multi_cycle_ctrl dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .opcode_i        (opcode_i),
      .mem_ready_i     (mem_ready_i),
      .pc_write_o      (pc_write_o),
      .pc_write_cond_o (pc_write_cond_o),
      .branch_ne_o     (branch_ne_o),
      .pc_source_o     (pc_source_o),
      .i_or_d_o        (i_or_d_o),
      .mem_read_o      (mem_read_o),
      .mem_write_o     (mem_write_o),
      .ir_write_o      (ir_write_o),
      .reg_write_o     (reg_write_o),
      .reg_dst_o       (reg_dst_o),
      .mem_to_reg_o    (mem_to_reg_o),
      .ext_zero_o      (ext_zero_o),
      .alu_src_a_o     (alu_src_a_o),
      .alu_src_b_o     (alu_src_b_o),
      .alu_op_o        (alu_op_o),
      .instr_done_o    (instr_done_o),
      .illegal_o       (illegal_o),
      .state_o         (state_o)
`ifdef MULTI_CYCLE_CTRL_PERF_EN
      ,
      .cycle_cnt_o     (cycle_cnt),
      .instr_cnt_o     (instr_cnt)
`endif
   );

   logic [W-1:0] obs_v;
   assign obs_v = {state_o, pc_write_o, pc_write_cond_o, branch_ne_o, pc_source_o,
                   i_or_d_o, mem_read_o, mem_write_o, ir_write_o, reg_write_o,
                   reg_dst_o, mem_to_reg_o, ext_zero_o, alu_src_a_o, alu_src_b_o,
                   alu_op_o, instr_done_o, illegal_o};

   // ---------------------------------------------------------------- scoreboard
   logic [W-1:0] exp_q[$];
   logic [W-1:0] care_q[$];
   int checks   = 0;
   int failures = 0;
   int n_done   = 0;   // instructions the bench expects to have completed
   logic last_done;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Always-checked fields: state and every strobe. Mux selects are added to
   // the mask only in states where their value is defined.
   function automatic ctl_t care_strobes();
      ctl_t c;
      c = '0;
      c.state = '1; c.pc_write = 1'b1; c.pc_write_cond = 1'b1;
      c.mem_read = 1'b1; c.mem_write = 1'b1; c.ir_write = 1'b1;
      c.reg_write = 1'b1; c.ext_zero = 1'b1; c.instr_done = 1'b1; c.illegal = 1'b1;
      return c;
   endfunction

   function automatic logic [5:0] rnd_op();
      return 6'($urandom);
   endfunction

   // One clock cycle: queue expectation, drive inputs, compare outputs.
   task automatic cycle(input string tag, input logic rst, input logic rdy,
                        input logic [5:0] op, input ctl_t e, input ctl_t c);
      logic [W-1:0] ev, cv;
      exp_q.push_back(W'(e));
      care_q.push_back(W'(c));
      @(negedge clk);
      rst_i = rst; mem_ready_i = rdy; opcode_i = op;
      #1;
      ev = exp_q.pop_front();
      cv = care_q.pop_front();
      check_eq(tag, 64'(obs_v & cv), 64'(ev & cv));
      last_done = instr_done_o;
   endtask

   task automatic idle_cycle(input string tag, input logic rst);
      ctl_t all;
      all = '1;
      cycle(tag, rst, 1'b1, rnd_op(), '0, all);
   endtask

   // Drive one instruction from its first FETCH cycle. fw / mw are the number
   // of not-ready cycles in FETCH and in the memory state. exp_lat is the
   // expected FETCH-to-instr_done length (0 for illegal). With rst_in_wr the
   // reset is raised in the first MEM_WR cycle.
   task automatic run_instr(input string name, input logic [5:0] op, input int fw,
                            input int mw, input int exp_lat, input logic rst_in_wr);
      ctl_t e, c;
      int   n, done_at;
      logic legal;
      n = 0; done_at = 0;
      legal = (op inside {OP_R, OP_LW, OP_SW, OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI,
                          OP_BEQ, OP_BNE, OP_J});
      // FETCH
      c = care_strobes(); c.i_or_d = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = '1;
      c.alu_op = '1; c.pc_source = '1;
      for (int i = 0; i < fw + 1; i++) begin
         e = '0; e.state = 4'd1; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 3'b100;
         e.ir_write = (i == fw); e.pc_write = (i == fw);
         cycle({name, "_fetch"}, 1'b0, (i == fw), rnd_op(), e, c);
         n++;
      end
      // DECODE
      e = '0; e.state = 4'd2; e.alu_src_b = 2'b11; e.alu_op = 3'b100; e.illegal = !legal;
      c = care_strobes(); c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
      cycle({name, "_decode"}, 1'b0, 1'($urandom_range(0, 1)), op, e, c);
      n++;
      if (!legal) return;
      case (op)
         OP_R: begin
            e = '0; e.state = 4'd7; e.alu_src_a = 1'b1; e.alu_op = 3'b010;
            c = care_strobes(); c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
            cycle({name, "_exec"}, 1'b0, 1'($urandom_range(0, 1)), rnd_op(), e, c); n++;
            e = '0; e.state = 4'd8; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1;
            c = care_strobes(); c.reg_dst = 1'b1; c.mem_to_reg = 1'b1;
            cycle({name, "_wb"}, 1'b0, 1'($urandom_range(0, 1)), rnd_op(), e, c); n++;
            if (last_done) done_at = n;
         end
         OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI: begin
            e = '0; e.state = 4'd9; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            e.alu_op = (op == OP_ADDI) ? 3'b100 : (op == OP_SLTIU) ? 3'b111 :
                       (op == OP_LUI) ? 3'b101 : 3'b110;
            e.ext_zero = (op == OP_ORI);
            c = care_strobes(); c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
            cycle({name, "_exec"}, 1'b0, 1'($urandom_range(0, 1)), rnd_op(), e, c); n++;
            e = '0; e.state = 4'd10; e.reg_write = 1'b1; e.instr_done = 1'b1;
            c = care_strobes(); c.reg_dst = 1'b1; c.mem_to_reg = 1'b1;
            cycle({name, "_wb"}, 1'b0, 1'($urandom_range(0, 1)), rnd_op(), e, c); n++;
            if (last_done) done_at = n;
         end
         OP_LW, OP_SW: begin
            e = '0; e.state = 4'd3; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b100;
            c = care_strobes(); c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
            cycle({name, "_addr"}, 1'b0, 1'($urandom_range(0, 1)), rnd_op(), e, c); n++;
            c = care_strobes(); c.i_or_d = 1'b1;
            for (int i = 0; i < mw + 1; i++) begin
               e = '0; e.i_or_d = 1'b1;
               if (op == OP_LW) begin
                  e.state = 4'd4; e.mem_read = 1'b1;
               end else begin
                  e.state = 4'd6; e.mem_write = 1'b1; e.instr_done = (i == mw) && !rst_in_wr;
               end
               if (rst_in_wr) begin
                  cycle({name, "_mem_rst"}, 1'b1, 1'b0, rnd_op(), e, c);
                  return;
               end
               cycle({name, "_mem"}, 1'b0, (i == mw), rnd_op(), e, c); n++;
               if (last_done) done_at = n;
            end
            if (op == OP_LW) begin
               e = '0; e.state = 4'd5; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
               c = care_strobes(); c.reg_dst = 1'b1; c.mem_to_reg = 1'b1;
               cycle({name, "_wb"}, 1'b0, 1'($urandom_range(0, 1)), rnd_op(), e, c); n++;
               if (last_done) done_at = n;
            end
         end
         OP_BEQ, OP_BNE: begin
            e = '0; e.state = 4'd11; e.alu_src_a = 1'b1;
            e.alu_op = (op == OP_BNE) ? 3'b001 : 3'b011; e.branch_ne = (op == OP_BNE);
            e.pc_write_cond = 1'b1; e.pc_source = 2'b01; e.instr_done = 1'b1;
            c = care_strobes(); c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
            c.branch_ne = 1'b1; c.pc_source = '1;
            cycle({name, "_branch"}, 1'b0, 1'($urandom_range(0, 1)), rnd_op(), e, c); n++;
            if (last_done) done_at = n;
         end
         default: begin   // jump
            e = '0; e.state = 4'd12; e.pc_write = 1'b1; e.pc_source = 2'b10; e.instr_done = 1'b1;
            c = care_strobes(); c.pc_source = '1;
            cycle({name, "_jump"}, 1'b0, 1'($urandom_range(0, 1)), rnd_op(), e, c); n++;
            if (last_done) done_at = n;
         end
      endcase
      n_done++;
      check_eq({name, "_latency"}, 64'(done_at), 64'(exp_lat));
   endtask

   function automatic int base_lat(input logic [5:0] op);
      case (op)
         OP_LW:                 return 5;
         OP_BEQ, OP_BNE, OP_J:  return 3;
         default:               return 4;
      endcase
   endfunction

   // ------------------------------------------------------------ main sequence
   logic [5:0] ops [10];
`ifdef MULTI_CYCLE_CTRL_PERF_EN
   logic [31:0] icnt_before;
`endif

   initial begin
      ops = '{OP_R, OP_LW, OP_SW, OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI, OP_BEQ, OP_BNE, OP_J};

      // Reset held 3 cycles with ready high, then released: IDLE, then FETCH.
      for (int i = 0; i < 3; i++) idle_cycle("reset_idle", 1'b1);
      idle_cycle("reset_release", 1'b0);
`ifdef MULTI_CYCLE_CTRL_PERF_EN
      check_eq("perf_after_reset", {cycle_cnt, instr_cnt}, 64'd0);
`endif

      run_instr("rtype",  OP_R,     0, 0, 4, 1'b0);
      run_instr("lw_wait", OP_LW,   2, 2, 9, 1'b0);
      run_instr("bne",    OP_BNE,   0, 0, 3, 1'b0);
`ifdef MULTI_CYCLE_CTRL_PERF_EN
      icnt_before = instr_cnt;
`endif
      run_instr("illegal", 6'b111111, 0, 0, 0, 1'b0);
      run_instr("illegal2", 6'b000001, 1, 0, 0, 1'b0);
`ifdef MULTI_CYCLE_CTRL_PERF_EN
      check_eq("illegal_icnt", 64'(instr_cnt), 64'(icnt_before));
`endif
      run_instr("addi",  OP_ADDI,  0, 0, 4, 1'b0);
      run_instr("sltiu", OP_SLTIU, 0, 0, 4, 1'b0);
      run_instr("lui",   OP_LUI,   0, 0, 4, 1'b0);
      run_instr("ori",   OP_ORI,   1, 0, 5, 1'b0);
      run_instr("beq",   OP_BEQ,   0, 0, 3, 1'b0);
      run_instr("jump",  OP_J,     0, 0, 3, 1'b0);
      run_instr("sw",    OP_SW,    0, 0, 4, 1'b0);
      run_instr("sw_wait", OP_SW,  1, 2, 7, 1'b0);
      run_instr("lw",    OP_LW,    0, 0, 5, 1'b0);

      for (int k = 0; k < 12; k++) begin
         logic [5:0] op;
         int fw, mw, lat;
         op  = ops[$urandom_range(0, 9)];
         fw  = $urandom_range(0, 2);
         mw  = (op == OP_LW || op == OP_SW) ? $urandom_range(0, 2) : 0;
         lat = base_lat(op) + fw + mw;
         run_instr("rand", op, fw, mw, lat, 1'b0);
      end
`ifdef MULTI_CYCLE_CTRL_PERF_EN
      check_eq("instr_cnt_total", 64'(instr_cnt), 64'(n_done));
`endif

      // Reset while a store is waiting: the request is dropped at once.
      run_instr("sw_reset", OP_SW, 0, 1, 0, 1'b1);
      idle_cycle("reset_in_memwr", 1'b0);
`ifdef MULTI_CYCLE_CTRL_PERF_EN
      check_eq("perf_reset_in_memwr", {cycle_cnt, instr_cnt}, 64'd0);
`endif
      run_instr("after_reset", OP_R, 0, 0, 4, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

endmodule
